// File: rtl/cordic_pkg.sv
// Constants, angle type and state encoding shared by the CORDIC unit,
// its atan table and the angle preparation stage.
package cordic_pkg;

  localparam int unsigned FRAC = 29;

  // Q.29 integer encodings of the angle constants used for range reduction
  localparam longint PI      = 64'sd1686629713;
  localparam longint TWO_PI  = 64'sd3373259426;
  localparam longint HALF_PI = 64'sd843314857;

  typedef logic signed [31:0] angle_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    FOLD   = 2'd2,
    HOLD   = 2'd3
  } state_e;

endpackage

// File: rtl/cordic_quadrant_fold.sv
// Combinational fold of a reduced magnitude m in [0, 2pi) with sign s into
// [-pi/2, +pi/2] plus a flag telling the CORDIC to negate its outputs.
module cordic_quadrant_fold
  import cordic_pkg::*;
#(
  parameter int unsigned IN_W = 40
) (
  input  logic [IN_W-1:0] m_i,
  input  logic            s_i,
  output logic [31:0]     angle_c_o,
  output logic            neg_c_o
);

  localparam int unsigned W = IN_W + 1;

  localparam logic signed [W-1:0] PI_W     = W'(PI);
  localparam logic signed [W-1:0] TWO_PI_W = W'(TWO_PI);
  localparam logic signed [W-1:0] HALF_W   = W'(HALF_PI);

  logic signed [W-1:0] m_w;
  logic signed [W-1:0] wrap_c;
  logic signed [W-1:0] sgn_c;
  logic signed [W-1:0] fold_c;

  always_comb begin
    neg_c_o = 1'b0;
    m_w     = $signed({1'b0, m_i});
    // map [0, 2pi) onto (-pi, pi], then restore the input sign
    wrap_c  = (m_w > PI_W) ? (m_w - TWO_PI_W) : m_w;
    sgn_c   = s_i ? -wrap_c : wrap_c;
    fold_c  = sgn_c;
    if (sgn_c > HALF_W) begin
      fold_c  = sgn_c - PI_W;
      neg_c_o = 1'b1;
    end else if (sgn_c < -HALF_W) begin
      fold_c  = sgn_c + PI_W;
      neg_c_o = 1'b1;
    end
    angle_c_o = fold_c[31:0];
  end

endmodule

// File: rtl/cordic_angle_prep.sv
// Reduces a wide signed radian angle modulo 2pi and folds it into the CORDIC
// range. Optional one-cycle bypass for small angles: CORDIC_PREP_FASTPATH_EN.
module cordic_angle_prep
  import cordic_pkg::*;
#(
  parameter int unsigned IN_W = 40
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_angle,
  input  logic            in_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_angle,
  output logic            out_neg,
  output logic            out_mode
);

  localparam int unsigned K   = IN_W - 33;
  localparam int unsigned K_W = (K < 1) ? 1 : $clog2(K + 1);

`ifdef CORDIC_PREP_FASTPATH_EN
  localparam logic signed [IN_W-1:0] HALF_IN = IN_W'(HALF_PI);
`endif

  state_e          state_q, state_d;
  logic [IN_W-1:0] m_q, m_d;
  logic            s_q, s_d;
  logic [K_W-1:0]  k_q, k_d;
  logic            mode_q, mode_d;
  angle_t          angle_q, angle_d;
  logic            neg_q, neg_d;
  logic            valid_q, valid_d;

  logic [IN_W-1:0] sub_c;
  logic [31:0]     fold_angle_c;
  logic            fold_neg_c;

  cordic_quadrant_fold #(
    .IN_W (IN_W)
  ) u_fold (
    .m_i       (m_q),
    .s_i       (s_q),
    .angle_c_o (fold_angle_c),
    .neg_c_o   (fold_neg_c)
  );

  assign in_ready  = !rst && (state_q == IDLE);
  assign out_valid = valid_q;
  assign out_angle = angle_q;
  assign out_neg   = neg_q;
  assign out_mode  = mode_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      s_q     <= 1'b0;
      k_q     <= '0;
      mode_q  <= 1'b0;
      angle_q <= '0;
      neg_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
      k_q     <= k_d;
      mode_q  <= mode_d;
      angle_q <= angle_d;
      neg_q   <= neg_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    k_d     = k_q;
    mode_d  = mode_q;
    angle_d = angle_q;
    neg_d   = neg_q;
    valid_d = valid_q;
    sub_c   = IN_W'(TWO_PI) << k_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          // magnitude is unsigned so the most negative input still fits
          s_d    = in_angle[IN_W-1];
          m_d    = in_angle[IN_W-1] ? (~in_angle + IN_W'(1)) : in_angle;
          mode_d = in_mode;
          k_d    = K_W'(K);
          state_d = REDUCE;
`ifdef CORDIC_PREP_FASTPATH_EN
          if (($signed(in_angle) >= -HALF_IN) && ($signed(in_angle) <= HALF_IN)) begin
            angle_d = in_angle[31:0];
            neg_d   = 1'b0;
            valid_d = 1'b1;
            state_d = HOLD;
          end
`endif
        end
      end
      REDUCE: begin
        // restoring subtraction of 2pi*2^k, largest multiple first
        if (m_q >= sub_c) begin
          m_d = m_q - sub_c;
        end
        if (k_q == '0) begin
          state_d = FOLD;
        end else begin
          k_d = k_q - K_W'(1);
        end
      end
      FOLD: begin
        angle_d = fold_angle_c;
        neg_d   = fold_neg_c;
        valid_d = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cordic_angle_prep.sv
// Self-checking bench for cordic_angle_prep: directed and random angles
// against an arithmetic modulo/fold reference, with backpressure and reset.
module tb_cordic_angle_prep;
  import cordic_pkg::*;

  localparam int unsigned IN_W = 40;
  localparam int FULL_LAT = IN_W - 31;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] in_angle;
  logic            in_mode;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_angle;
  logic            out_neg;
  logic            out_mode;

  logic [IN_W-1:0] g_m;
  logic            g_s;
  logic [31:0]     g_angle;
  logic            g_neg;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  cordic_angle_prep #(.IN_W(IN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_angle  (in_angle),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_angle (out_angle),
    .out_neg   (out_neg),
    .out_mode  (out_mode)
  );

  cordic_quadrant_fold #(.IN_W(IN_W)) u_gold (
    .m_i       (g_m),
    .s_i       (g_s),
    .angle_c_o (g_angle),
    .neg_c_o   (g_neg)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  // Reference: sign-magnitude remainder modulo 2pi, then quadrant fold.
  function automatic void ref_model(input longint a, output longint m, output bit s,
                                    output longint r, output bit neg);
    s = (a < 0);
    m = (s ? -a : a) % TWO_PI;
    r = (m > PI) ? m - TWO_PI : m;
    if (s) r = -r;
    neg = 1'b0;
    if (r > HALF_PI) begin
      r = r - PI; neg = 1'b1;
    end else if (r < -HALF_PI) begin
      r = r + PI; neg = 1'b1;
    end
  endfunction

  function automatic int exp_latency(input longint a);
`ifdef CORDIC_PREP_FASTPATH_EN
    if (a >= -HALF_PI && a <= HALF_PI) return 1;
`endif
    return FULL_LAT;
  endfunction

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check({tag, "_ready_timeout"}, 0, 1);
  endtask

  task automatic run_txn(input string tag, input longint a, input bit mode, input int hold);
    longint em, er;
    bit     es, eneg;
    int     lat;
    logic [31:0] a_snap;
    ref_model(a, em, es, er, eneg);
    @(negedge clk);
    wait_ready(tag);
    in_valid = 1'b1;
    in_angle = IN_W'(a);
    in_mode  = mode;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!out_valid && lat < 50);
    check({tag, "_latency"}, lat, exp_latency(a));
    check({tag, "_angle"}, longint'($signed(out_angle)), er);
    check({tag, "_neg"}, out_neg, eneg);
    check({tag, "_mode"}, out_mode, mode);
    g_m = IN_W'(em);
    g_s = es;
    #1;
    check({tag, "_gold_angle"}, longint'($signed(g_angle)), er);
    check({tag, "_gold_neg"}, g_neg, eneg);
    a_snap = out_angle;
    // stall with a competing request that must not be taken
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_angle = IN_W'(a + 64'sd12345);
      @(posedge clk);
      #1;
      check({tag, "_stall_valid"}, out_valid, 1);
      check({tag, "_stall_angle"}, longint'(out_angle), longint'(a_snap));
      check({tag, "_stall_ready"}, in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, "_done_valid"}, out_valid, 0);
    check({tag, "_done_ready"}, in_ready, 1);
  endtask

  initial begin
    longint a;
    logic [IN_W-1:0] raw;
    rst = 1'b1;
    in_valid = 1'b0;
    in_angle = '0;
    in_mode = 1'b0;
    out_ready = 1'b0;
    g_m = '0;
    g_s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_angle", out_angle, 0);
    check("rst_out_neg", out_neg, 0);
    check("rst_out_mode", out_mode, 0);
    @(negedge clk) rst = 1'b0;
    #1 check("post_rst_ready", in_ready, 1);

    run_txn("pi_3", 64'sd562209905, 1'b1, 0);
    check("pi_3_exact", 64'sd562209905, longint'($signed(dut.angle_q)));
    run_txn("2pi_3", 64'sd1124419809, 1'b0, 0);
    run_txn("10pi_pos", 64'sd17428507035, 1'b1, 1);
    run_txn("10pi_neg", -64'sd17428507035, 1'b0, 0);
    run_txn("pi", 64'sd1686629713, 1'b0, 0);
    run_txn("neg_pi", -64'sd1686629713, 1'b1, 0);
    run_txn("neg_half", -64'sd843314857, 1'b0, 0);
    run_txn("half", 64'sd843314857, 1'b1, 0);
    run_txn("zero", 64'sd0, 1'b0, 0);
    run_txn("min", -(64'sd1 <<< 39), 1'b1, 0);
    run_txn("max", (64'sd1 <<< 39) - 1, 1'b0, 0);
    run_txn("bp5", 64'sd1124419809, 1'b1, 5);

    // abort in the middle of REDUCE
    @(negedge clk);
    wait_ready("abort");
    in_valid = 1'b1;
    in_angle = IN_W'(64'sd17428507035);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_ready", in_ready, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 check("abort_ready_after", in_ready, 1);
    for (int i = 0; i < FULL_LAT + 2; i++) begin
      @(posedge clk);
      #1 check("abort_no_output", out_valid, 0);
    end
    run_txn("after_abort", 64'sd562209905, 1'b1, 0);

    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) begin
        raw = IN_W'({$urandom(), $urandom()});
        a = longint'($signed(raw));
      end else begin
        a = longint'($urandom_range(0, 32'd2 * 32'd1686629713)) - PI;
      end
      run_txn($sformatf("rnd%0d", i), a, 1'(($urandom() >> 3) & 1), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cordic_angle_prep.md
Name: cordic_angle_prep

Overview:
- Upstream stage of the CORDIC unit. Accepts an arbitrary wide signed angle in radians and reduces it modulo 2pi.
- Folds the result into the CORDIC convergence range [-pi/2, +pi/2] and emits it as a 32-bit Q3.29 angle.
- Emits a negate flag: out_neg=1 means the downstream sin/cos (and rotated X/Y) must be negated.
- Uses a valid/ready handshake on both sides; reduction is a multi-cycle restoring-subtraction FSM.

Parameters:
- IN_W, 40, input angle width; signed Q(IN_W-29).29, must be >= 33.
- FRAC, 29, fractional bits; fixed to match the CORDIC angle format.
- K (localparam), IN_W-33, highest reduction step index; steps subtract 2pi*2^k for k=K..0.

Ports:
- clk, in, 1, single clock; all logic on the rising edge.
- rst, in, 1, asynchronous active-high reset.
- in_valid, in, 1, input angle valid.
- in_ready, out, 1, block can accept an angle.
- in_angle, in, IN_W, signed Q(IN_W-29).29 radians.
- in_mode, in, 1, trig_rot tag; passed through unchanged.
- out_valid, out, 1, reduced angle valid.
- out_ready, in, 1, CORDIC stage accepts the result.
- out_angle, out, 32, signed Q3.29, range [-pi/2, +pi/2].
- out_neg, out, 1, negate CORDIC outputs.
- out_mode, out, 1, captured in_mode.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (clk, rst).
- Reset values: state=IDLE, out_valid=0, out_angle=0, out_neg=0, out_mode=0. in_ready=0 while rst is high, and = (state==IDLE) otherwise.
- Constants (Q.29 integers): PI=1686629713, TWO_PI=3373259426, HALF_PI=843314857.
- States: IDLE, REDUCE, FOLD, HOLD.
- IDLE: on in_valid&&in_ready at edge E0:
  - capture s=sign(in_angle) and m=|in_angle| (IN_W-bit unsigned; the most negative input is legal), plus in_mode.
  - set k=K and go to REDUCE.
- REDUCE: one step per edge, E1..E(K+1).
  - If m >= TWO_PI<<k, then m -= TWO_PI<<k.
  - k decrements; after k=0, go to FOLD. m is now in [0, 2pi).
- FOLD, single edge E(K+2):
  - r = (m > PI) ? m-TWO_PI : m.
  - r = s ? -r : r.
  - If r > HALF_PI: r -= PI, neg=1. Else if r < -HALF_PI: r += PI, neg=1. Else neg=0.
  - Register out_angle=r[31:0], out_neg, out_mode; set out_valid=1; go to HOLD.
- Latency: out_valid is high after edge E(K+2); with default K=7 that is 9 cycles after the accept edge.
- HOLD:
  - out_* held stable while out_ready=0.
  - On out_valid&&out_ready: out_valid=0 and go to IDLE; in_ready rises the following cycle (no same-cycle accept).
- Boundaries:
  - |r| == HALF_PI exactly: no fold, neg=0.
  - input PI gives 0, neg=1. Input -PI gives 0, neg=1.
  - input 0 gives 0, neg=0.
  - All arithmetic is done at IN_W+1 bits signed; the final r always fits in Q3.29.
- rst mid-operation: aborts immediately, no output produced, returns to IDLE.
- in_valid while busy is ignored; the upstream must hold it until in_ready.

Optional Feature:
- Macro: CORDIC_PREP_FASTPATH_EN.
- Defined:
  - At accept, if -HALF_PI <= in_angle <= HALF_PI, skip REDUCE/FOLD.
  - Load out_angle=in_angle[31:0], out_neg=0, out_valid=1 at E0 itself and enter HOLD; out_valid is visible one cycle after accept.
- Undefined: every angle takes the full K+2-cycle path. Results are bit-identical either way; only latency differs.

Decomposition:
- Package cordic_pkg:
  - Q3.29 constants PI, TWO_PI, HALF_PI.
  - FRAC.
  - state enum (IDLE/REDUCE/FOLD/HOLD).
  - Q3.29 angle typedef.
  - These are shared with the CORDIC unit and its atan table.
- Natural sub-module: cordic_quadrant_fold, a combinational FOLD step (m, s -> r, neg). It is instanced once and also reused by the bench as the golden-model checker.

Test Plan:
- Nominal: in_angle=562209905 (pi/3), mode=1 -> out_valid after 9 cycles, out_angle=562209905, out_neg=0, out_mode=1.
- Second quadrant: in_angle=1124419809 (2pi/3) -> out_angle=-562209904, out_neg=1.
- Multi-turn, both signs:
  - in_angle=17428507035 (10pi+pi/3) -> 562209905, neg=0.
  - in_angle=-17428507035 -> -562209905, neg=0.
- Boundaries:
  - 1686629713 (pi) -> 0, neg=1.
  - -843314857 (-pi/2) -> -843314857, neg=0.
  - -2^39 -> bit-exact match with the golden model.
- Backpressure: out_ready=0 for 5 cycles after out_valid.
  - Outputs stay stable, in_ready=0, a new in_valid is not accepted.
  - Release out_ready -> handshake completes, in_ready=1 the next cycle.
- Reset mid-REDUCE: assert rst at cycle 4 after accept -> out_valid stays 0, in_ready=1 the cycle after rst falls, the next angle processes correctly.
- Fastpath, CORDIC_PREP_FASTPATH_EN defined: pi/3 -> out_valid 1 cycle after accept; 2pi/3 -> still 9 cycles.
